// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared constants, FSM state type, result struct and the
// leading-zero helper for the fpcvt_scheduler block.
//   IN_W/EXP_W/SIG_W : sample, exponent and significand widths
//   LZ_CAP           : maximum normalisation shift
//   EXP_MAX/SIG_MAX  : saturation values
//   state_e          : IDLE, SCAN, ROUND, DONE
//   fp8_t            : {sign, exp, sig} packed result
//   lz_count()       : priority-encoded leading-zero count, capped at LZ_CAP
package fpcvt_pkg;

    localparam int IN_W    = 12;
    localparam int EXP_W   = 3;
    localparam int SIG_W   = 4;
    localparam int LZ_CAP  = 8;
    localparam int EXP_MAX = 7;
    localparam int SIG_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp8_t;

    // Scan from the LSB side of the window toward the MSB so the highest
    // set bit (smallest count) is the last to overwrite n.
    function automatic logic [3:0] lz_count(input logic [IN_W-1:0] v);
        logic [3:0] n;
        n = 4'(LZ_CAP);
        for (int i = LZ_CAP - 1; i >= 0; i--) begin
            if (v[IN_W-1-i]) n = 4'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// fpcvt_round: combinational packing of a normalised magnitude into
// {exp, sig} with round-to-nearest (ties up), carry renormalisation and
// saturation.
//   top_i : sh[11:7] of the normalised shift register (4 sig bits + round bit)
//   lz_i  : shift count applied, 0..8
//   exp_o : exponent E
//   sig_o : significand F (value = F * 2^E)
module fpcvt_round
    import fpcvt_pkg::*;
(
    input  logic [4:0]       top_i,
    input  logic [3:0]       lz_i,
    output logic [EXP_W-1:0] exp_o,
    output logic [SIG_W-1:0] sig_o
);

    logic [3:0] e;
    logic [4:0] f;
    logic       fifth;
    logic       denorm;

    // lz at the cap means the value is already an exact integer 0..15.
    assign denorm = (lz_i >= 4'(LZ_CAP));

    always_comb begin
        e     = denorm ? 4'd0 : 4'(LZ_CAP) - lz_i;
        fifth = denorm ? 1'b0 : top_i[0];
        f     = {1'b0, top_i[4:1]} + {4'd0, fifth};
        // Rounding overflow: 16 * 2^E == 8 * 2^(E+1).
        if (f[4]) begin
            f = 5'd8;
            e = e + 4'd1;
        end
        // lz=0 means the magnitude is 2048, which is beyond range.
        if (lz_i == 4'd0 || e > 4'(EXP_MAX)) begin
            exp_o = EXP_W'(EXP_MAX);
            sig_o = SIG_W'(SIG_MAX);
        end else begin
            exp_o = e[EXP_W-1:0];
            sig_o = f[SIG_W-1:0];
        end
    end

endmodule

// File: rtl/fpcvt_scheduler.sv
// fpcvt_scheduler: round-robin shares one 12-bit linear to 8-bit float
// converter between N_REQ requesters. Single entry: one sample is in flight
// from accept until the result is taken on the out valid/ready port.
//   clk, rst               : clock, async active-high reset
//   req_valid/req_data     : per-requester sample offer (12 bits each)
//   req_ready              : one-hot accept, only in IDLE
//   out_valid/out_ready    : result handshake
//   out_id/sign/exp/sig    : result owner and fields
//   busy                   : any state but IDLE
// Build option: define FPCVT_FAST_NORM_EN to normalise in a single SCAN
// cycle with a priority encoder instead of shifting one bit per cycle.
module fpcvt_scheduler
    import fpcvt_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [IN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_sign,
    output logic [EXP_W-1:0]      out_exp,
    output logic [SIG_W-1:0]      out_sig,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              sign_q, sign_d;
    logic [IN_W-1:0]   sh_q, sh_d;
    logic [3:0]        lz_q, lz_d;
    fp8_t              res_q, res_d;
    logic              vld_q, vld_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   win;
    logic              found;
    logic [ID_W:0]     cand;
    logic [IN_W-1:0]   samp;
    logic [IN_W-1:0]   mag;
    logic [EXP_W-1:0]  rnd_exp;
    logic [SIG_W-1:0]  rnd_sig;

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found                   = 1'b1;
                win                     = cand[ID_W-1:0];
                grant[cand[ID_W-1:0]]   = 1'b1;
            end
        end
    end

    assign samp = req_data[IN_W*win +: IN_W];
    // 12'h800 negates to itself, which reads correctly as unsigned 2048.
    assign mag  = samp[IN_W-1] ? (~samp + 1'b1) : samp;

    fpcvt_round u_round (
        .top_i (sh_q[IN_W-1 -: 5]),
        .lz_i  (lz_q),
        .exp_o (rnd_exp),
        .sig_o (rnd_sig)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sign_d  = sign_q;
        sh_d    = sh_q;
        lz_d    = lz_q;
        res_d   = res_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = win;
                    sign_d  = samp[IN_W-1];
                    sh_d    = mag;
                    lz_d    = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef FPCVT_FAST_NORM_EN
                lz_d    = lz_count(sh_q);
                sh_d    = sh_q << lz_count(sh_q);
                state_d = ROUND;
`else
                if (sh_q[IN_W-1] || lz_q == 4'(LZ_CAP)) begin
                    state_d = ROUND;
                end else begin
                    sh_d = sh_q << 1;
                    lz_d = lz_q + 4'd1;
                end
`endif
            end
            ROUND: begin
                res_d.sign = sign_q;
                res_d.exp  = rnd_exp;
                res_d.sig  = rnd_sig;
                vld_d      = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            sign_q  <= 1'b0;
            sh_q    <= '0;
            lz_q    <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sign_q  <= sign_d;
            sh_q    <= sh_d;
            lz_q    <= lz_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign out_valid = vld_q;
    assign out_id    = id_q;
    assign out_sign  = res_q.sign;
    assign out_exp   = res_q.exp;
    assign out_sig   = res_q.sig;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpcvt_scheduler.sv
module tb_fpcvt_scheduler;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [12*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_id;
    logic            out_sign;
    logic [2:0]      out_exp;
    logic [3:0]      out_sig;
    logic            busy;

    int checks = 0;
    int errors = 0;

    fpcvt_scheduler #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = F * 2^E with round-half-up, from integer arithmetic.
    function automatic logic [9:0] ref_word(input int r, input logic [11:0] d, output int lz);
        int v, mag, s, e, f;
        v   = d[11] ? int'(d) - 4096 : int'(d);
        s   = (v < 0) ? 1 : 0;
        mag = (v < 0) ? -v : v;
        lz  = 0;
        while (lz < 8 && mag < (2048 >> lz)) lz++;
        if (lz == 0) begin
            e = 7; f = 15;
        end else if (lz == 8) begin
            e = 0; f = mag;
        end else begin
            e = 8 - lz;
            f = (mag + (1 << (e - 1))) >> e;
            if (f == 16) begin f = 8; e = e + 1; end
            if (e > 7) begin e = 7; f = 15; end
        end
        return {2'(r), 1'(s), 3'(e), 4'(f)};
    endfunction

    function automatic int exp_lat(input int lz);
`ifdef FPCVT_FAST_NORM_EN
        return (lz < 0) ? 0 : 3;
`else
        return lz + 3;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one sample on requester r alone, measure latency, take result.
    task automatic run_one(input int r, input logic [11:0] d, output logic acc,
                           output int lat, output logic [9:0] got);
        @(negedge clk);
        req_data = 48'({$urandom(), $urandom()});
        req_data[12*r +: 12] = d;
        req_valid = 4'(1 << r);
        #1 acc = (req_ready == 4'(1 << r));
        @(posedge clk);
        #1 req_valid = '0;
        req_data = 48'({$urandom(), $urandom()});
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        got = {out_id, out_sign, out_exp, out_sig};
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; out_ready = 1'b0; req_data = '0;
        #3;
        checks++;
        if ({out_valid, out_id, out_sign, out_exp, out_sig, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {out_valid, out_id, out_sign, out_exp, out_sig, busy, req_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got ready=%b busy=%b want ready=0001 busy=0", req_ready, busy);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_directed();
        int         rr[6]   = '{0, 1, 1, 2, 2, 3};
        logic [11:0] dd[6]  = '{12'd422, 12'd46, 12'd125, 12'h800, 12'd2047, 12'hFFB};
        int         lzv[6]  = '{3, 6, 5, 0, 1, 8};
        logic [9:0] want[6] = '{{2'd0, 1'b0, 3'd5, 4'd13}, {2'd1, 1'b0, 3'd2, 4'd12},
                                {2'd1, 1'b0, 3'd4, 4'd8},  {2'd2, 1'b1, 3'd7, 4'd15},
                                {2'd2, 1'b0, 3'd7, 4'd15}, {2'd3, 1'b1, 3'd0, 4'd5}};
        logic acc; int lat; logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            run_one(rr[i], dd[i], acc, lat, got);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL dir_accept[%0d]: got 0 want 1", i);
            end
            checks++;
            if (got !== want[i]) begin
                errors++;
                $display("FAIL dir_fields[%0d]: got %h want %h", i, got, want[i]);
            end
            checks++;
            if (lat != exp_lat(lzv[i])) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, exp_lat(lzv[i]));
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir_release[%0d]: got valid=%b busy=%b want 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic acc; int lat, lz, r; logic [9:0] got, want; logic [11:0] d;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, N - 1);
            case ($urandom_range(0, 3))
                0:       d = 12'($urandom_range(0, 40));
                1:       d = 12'(-$urandom_range(0, 40));
                default: d = 12'($urandom);
            endcase
            want = ref_word(r, d, lz);
            run_one(r, d, acc, lat, got);
            checks++;
            if (!acc || got !== want || lat != exp_lat(lz)) begin
                errors++;
                $display("FAIL rand[%0d] d=%h: got acc=%b w=%h lat=%0d want 1 %h %0d",
                         i, d, acc, got, lat, want, exp_lat(lz));
            end
        end
    endtask

    task automatic test_stall();
        logic [11:0] dat[4];
        int order[5] = '{0, 1, 2, 3, 0};
        int win, lz, c;
        logic [9:0] held, want;
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 12'($urandom);
        @(negedge clk);
        for (int i = 0; i < N; i++) req_data[12*i +: 12] = dat[i];
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            c = 0;
            #1;
            while (req_ready == '0 && c < 20) begin @(negedge clk); #1 c++; end
            win = -1;
            for (int i = 0; i < N; i++) if (req_ready == 4'(1 << i)) win = i;
            checks++;
            if (win != order[n]) begin
                errors++;
                $display("FAIL stall_order[%0d]: got %0d want %0d", n, win, order[n]);
            end
            want = ref_word(order[n], dat[order[n]], lz);
            c = 0;
            @(negedge clk);
            while (!out_valid && c < 30) begin @(negedge clk); c++; end
            held = {out_id, out_sign, out_exp, out_sig};
            checks++;
            if (held !== want || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_fields[%0d]: got v=%b %h want 1 %h", n, out_valid, held, want);
            end
            if (n == 0) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || {out_id, out_sign, out_exp, out_sig} !== held ||
                        req_ready !== '0) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: got v=%b %h rdy=%b want 1 %h 0000", k,
                                 out_valid, {out_id, out_sign, out_exp, out_sig}, req_ready, held);
                    end
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic acc; int lat, c, bad; logic [9:0] got;
        do_reset();
        run_one(1, 12'd300, acc, lat, got);   // leaves the pointer at 2
        @(negedge clk);
        req_data[24 +: 12] = 12'd40;          // lz = 6
        req_valid = 4'b0100;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #2 rst = 1'b1; req_valid = '1;
        #1;
        checks++;
        if ({out_valid, out_id, out_sign, out_exp, out_sig, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %0h want 0",
                     {out_valid, out_id, out_sign, out_exp, out_sig, busy, req_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_discard: got %0d active cycles want 0", bad);
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        c = 0;
        while (!out_valid && c < 30) begin @(negedge clk); c++; end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpcvt_scheduler.md
Name: fpcvt_scheduler

Overview:
- Shares one 12-bit linear-to-floating-point conversion datapath between N_REQ requesters.
- Arbitrates round-robin and captures a two's-complement sample from the winner.
- Sequences sign-magnitude conversion, iterative leading-zero normalisation and round-to-nearest packing into {sign, 3-bit exponent, 4-bit significand}.
- Presents the result with the requester ID on a valid/ready output port.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of out_id; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester sample valid.
- req_data  in  12*N_REQ  two's-complement samples; requester i occupies bits [12*i+11:12*i].
- req_ready  out  N_REQ  one-hot accept; combinational, asserted only in IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_id  out  ID_W  index of the requester that owns the result.
- out_sign  out  1  sign bit.
- out_exp  out  3  exponent E.
- out_sig  out  4  significand F; value = F * 2^E.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, rr pointer=0. All outputs 0, including out_valid, out_id, out_sign, out_exp, out_sig and busy. An in-flight conversion is discarded; no result is emitted for it.
- IDLE:
  - Winner = first i with req_valid[i], searching from the pointer upward with wrap.
  - req_ready[winner]=1 in the same cycle; the transfer occurs on that edge.
  - Capture: sign=data[11]; mag=|data|, 12-bit unsigned; id=winner. 12'h800 gives mag=2048 (bit 11 set).
  - Set shift register sh=mag, lz=0; go to SCAN. No valid request: stay in IDLE.
- SCAN, one decision per cycle:
  - If sh[11]=1 or lz=8: go to ROUND.
  - Otherwise sh<=sh<<1, lz<=lz+1.
- ROUND (packing lives in the sub-module):
  - lz=0: saturate, E=7, F=15.
  - lz=1..7: E=8-lz, F=sh[11:8], fifth=sh[7].
  - lz=8: E=0, F=sh[11:8] (= mag[3:0]), fifth=0.
  - If fifth=1: F=F+1. If F reaches 16: F=8, E=E+1. If E exceeds 7: E=7, F=15.
  - Register the fields; go to DONE.
- DONE:
  - out_valid=1; fields held stable until out_ready=1. Transfer on the edge where out_valid and out_ready are both high.
  - At that edge: pointer<=(id+1) mod N_REQ; go to IDLE. out_valid drops the next cycle.
  - No new request is accepted before then; the block is single-entry, with no back-to-back overlap.
- Latency: out_valid rises lz+3 cycles after the accept edge (3..11).
- req_valid and req_data changes outside the accept cycle have no effect.
- Zero input: mag=0, lz=8, E=0, F=0, sign=0.

Optional Feature:
- FPCVT_FAST_NORM_EN defined: SCAN lasts exactly one cycle. lz comes from a combinational priority encode, capped at 8, and sh=mag<<lz. Fixed latency of 3 cycles; results are identical to the iterative mode.
- Undefined: iterative shifting as above, with variable latency.

Decomposition:
- Shared package fpcvt_pkg:
  - Constants IN_W=12, EXP_W=3, SIG_W=4, LZ_CAP=8, EXP_MAX=7, SIG_MAX=15.
  - State enum {IDLE, SCAN, ROUND, DONE}.
  - Packed struct fp8_t {sign, exp, sig}.
- One sub-module, fpcvt_round: combinational, (sh[11:7], lz) -> (exp, sig), including the saturation and carry rules.

Test Plan:
- req 0 data 12'd422 -> lz=3, out E=5, F=13, sign 0; out_valid 6 cycles after the accept edge (3 in fast mode).
- req 1 data 12'd46 -> E=2, F=12, id=1. Then data 12'd125 -> carry gives E=4, F=8.
- req 2 data 12'h800 (-2048) -> sign 1, E=7, F=15. Then data 12'd2047 -> exponent overflow gives E=7, F=15, sign 0.
- req 3 data 12'hFFB (-5) -> sign 1, E=0, F=5; out_valid 11 cycles after accept.
- All four req_valid held high, out_ready held low for 5 cycles at the first DONE:
  - Fields stable during the stall; req_ready stays 0.
  - Accept order is 0, 1, 2, 3, 0.
- rst pulsed during SCAN of a conversion with lz=6:
  - All outputs 0 immediately; no out_valid for that sample.
  - The next accept goes to requester 0 when it is valid.
